pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised inter-stage pipeline register: successor to the fixed MEM/WB latch, usable at any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a control field and a data field through DEPTH register slices under a valid/ready handshake. It adds stall, flush and bubble collapsing, and control bits are forced to zero on every empty slot so no write-enable can fire from a bubble.

## Interface
- DATA_W, 64: payload width; non-control data such as read data and ALU result.
- CTRL_W, 2: control width; bits zeroed on bubble or flush, e.g. {reg_write, mem_to_reg}.
- DEPTH, 1: number of register slices, legal range 1..4.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-low reset.
- stall_i  in  1  freeze all slices. Ignored when flush_i=1.
- flush_i  in  1  invalidate all slices at next edge.
- in_valid_i  in  1  upstream has a beat.
- in_ready_o  out  1  slice 0 can accept this cycle.
- in_ctrl_i  in  CTRL_W  upstream control bits.
- in_data_i  in  DATA_W  upstream payload.
- out_valid_o  out  1  last slice holds a valid beat.
- out_ready_i  in  1  downstream consumes this cycle.
- out_ctrl_o  out  CTRL_W  control of last slice; all-zero whenever out_valid_o=0.
- out_data_o  out  DATA_W  payload of last slice; held, not cleared, when invalid.
- occupancy_o  out  $clog2(DEPTH+1)  number of valid slices.

## Operation
- Each slice k holds v[k], ctrl[k], data[k]. Define adv[DEPTH-1] = v[DEPTH-1] & out_ready_i.
- Slice k < DEPTH-1 may load when ~v[k+1] or adv[k+1]. Bubbles collapse: a beat moves forward into any empty slice ahead of it.
- Transfer into slice 0 occurs when in_valid_i & in_ready_o.
- in_ready_o = rst_i & ~stall_i & ~flush_i & (~v[0] | slice 0 moving forward). It is a combinational path from out_ready_i, rippled through DEPTH slices.
- A slice that empties without reload clears its v bit and ctrl; data is unchanged.
- stall_i=1 (flush_i=0): no slice changes, in_ready_o=0, and out_valid_o keeps its value. A downstream handshake on a stall cycle does not consume the beat; out_ready_i is ignored while stalled.
- flush_i=1: all v and ctrl are cleared at the next edge. The same-cycle input is dropped because in_ready_o=0. The same-cycle output handshake (out_valid_o & out_ready_i) still counts as consumed.
- Priority: rst_i low > flush_i > stall_i > normal advance.
- occupancy_o is the registered popcount of v, updated in the same edge as v.

## Timing
- Reset, on edge with rst_i=0: v=0, ctrl=0, data=0, so out_valid_o=0, out_ctrl_o=0, out_data_o=0, occupancy_o=0.
- in_ready_o=0 combinationally while rst_i=0.
- Latency: a beat accepted at edge n appears on out_valid_o after edge n+DEPTH-1. With DEPTH=1 it is visible in the cycle after acceptance.
- Throughput: one beat per cycle sustained when out_ready_i=1 and no stall.
- Full (occupancy=DEPTH) with out_ready_i=1: accept and emit in the same cycle, occupancy unchanged.
- Full with out_ready_i=0: in_ready_o=0.
- Empty with in_valid_i=1: accepted, occupancy goes from 0 to 1.
- Reset or flush mid-stream: every in-flight beat is lost and none reappears.

## Structure
- Package pipe_pkg:
  - MEMWB_CTRL_W=2, MEMWB_DATA_W=64, EXMEM_CTRL_W, IDEX_CTRL_W.
  - Bit-index constants CTRL_REG_WRITE=0, CTRL_MEM_TO_REG=1.
- Sub-module pipe_slice: one v/ctrl/data register with load, clear and hold controls. pipe_stage_reg instantiates DEPTH copies via generate and owns the ready ripple and the occupancy counter.
- MEM/WB is instantiated as pipe_stage_reg with CTRL_W=2, DATA_W=64, DEPTH=1.

## Test plan
- Reset: drive rst_i=0 for 2 cycles with in_valid_i=1 -> in_ready_o=0, out_valid_o=0, out_ctrl_o=0, occupancy_o=0; release -> first beat accepted next cycle.
- Streaming, DEPTH=3, out_ready_i=1: send beats 0x1..0x8 back-to-back with ctrl=2'b01 -> out_data_o 0x1..0x8 on consecutive cycles, first one 2 edges after acceptance, no gaps.
- Backpressure, DEPTH=2: hold out_ready_i=0 -> occupancy_o reaches 2 and in_ready_o=0; raise out_ready_i -> beats emitted in order with none lost or duplicated.
- Stall, DEPTH=2, full, ctrl=2'b11: stall_i=1 for 3 cycles with out_ready_i=1 -> outputs frozen and occupancy_o stays 2; release -> both beats emitted.
- Flush: full pipe plus in_valid_i=1 and flush_i=1 -> next cycle occupancy_o=0, out_valid_o=0, out_ctrl_o=2'b00, and the input beat never appears.
- Bubble collapse, DEPTH=4: inject beats only at cycles 0 and 3 with out_ready_i=0 -> occupancy_o=2 and both beats sit in slices 3 and 2.

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_pkg
//  Purpose  : Shared widths and control-bit layout for the inter-stage
//             pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Contents : stage control/data widths, MEM/WB control bit indices and a
//             packed view of the MEM/WB control field.
//  Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  // MEM/WB boundary: {mem_to_reg, reg_write} plus a 64-bit payload.
  localparam int MEMWB_CTRL_W = 2;
  localparam int MEMWB_DATA_W = 64;
  // EX/MEM adds mem_read and mem_write on top of the write-back pair.
  localparam int EXMEM_CTRL_W = 4;
  // ID/EX adds alu_src, two alu_op bits and branch.
  localparam int IDEX_CTRL_W  = 8;

  // Bit positions inside the MEM/WB control field.
  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_TO_REG = 1;

  // Packed view of the MEM/WB control field; first member is the MSB.
  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
  } memwb_ctrl_t;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_slice.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_slice
//  Purpose  : One pipeline register slot: valid bit, control field, payload.
//  Ports    : clk_i    - clock, rising edge
//             rst_i    - synchronous active-low reset (clears v, ctrl, data)
//             load_i   - capture ctrl_i/data_i and mark the slot valid
//             clear_i  - empty the slot: v and ctrl to 0, data held
//             ctrl_i   - incoming control bits
//             data_i   - incoming payload
//             valid_o  - slot holds a beat
//             ctrl_o   - control bits (zero whenever valid_o=0)
//             data_o   - payload (held when the slot empties)
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_slice
  import pipe_pkg::*;
#(
  parameter int CTRL_W = MEMWB_CTRL_W,
  parameter int DATA_W = MEMWB_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              v_d,    v_q;
  logic [CTRL_W-1:0] ctrl_d, ctrl_q;
  logic [DATA_W-1:0] data_d, data_q;

  // Load wins over clear so a slot that is vacated and refilled in the same
  // cycle keeps the new beat.
  always_comb begin
    v_d    = v_q;
    ctrl_d = ctrl_q;
    data_d = data_q;
    if (load_i) begin
      v_d    = 1'b1;
      ctrl_d = ctrl_i;
      data_d = data_i;
    end else if (clear_i) begin
      v_d    = 1'b0;
      ctrl_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      v_q    <= 1'b0;
      ctrl_q <= '0;
      data_q <= '0;
    end else begin
      v_q    <= v_d;
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end

  assign valid_o = v_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule : pipe_slice
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_reg
//  Purpose  : Parametrised inter-stage pipeline register, DEPTH slices deep,
//             with valid/ready handshake, stall, flush and bubble collapsing.
//             Control bits of every empty slot are zero.
//  Ports    : clk_i, rst_i (sync, active-low)
//             stall_i, flush_i           - freeze / invalidate all slices
//             in_valid_i, in_ready_o,
//             in_ctrl_i, in_data_i       - upstream handshake and beat
//             out_valid_o, out_ready_i,
//             out_ctrl_o, out_data_o     - downstream handshake and beat
//             occupancy_o                - registered count of valid slices
//  Params   : DATA_W, CTRL_W, DEPTH (1..4)
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = MEMWB_DATA_W,
  parameter int CTRL_W = MEMWB_CTRL_W,
  parameter int DEPTH  = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       stall_i,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [CTRL_W-1:0]          in_ctrl_i,
  input  logic [DATA_W-1:0]          in_data_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [CTRL_W-1:0]          out_ctrl_o,
  output logic [DATA_W-1:0]          out_data_o,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]  v;      // slice valid bits
  logic [DEPTH-1:0]  adv;    // slice k hands its beat on this cycle
  logic [DEPTH-1:0]  load;
  logic [DEPTH-1:0]  clear;
  logic [DEPTH-1:0]  v_nxt;
  logic [CTRL_W-1:0] ctrl [DEPTH];
  logic [DATA_W-1:0] data [DEPTH];
  logic              run;
  logic              in_fire;
  logic [OCC_W-1:0]  occ_d, occ_q;

  // Flush outranks stall; both freeze normal movement.
  assign run = ~stall_i & ~flush_i;

  // Ready ripples from the output back to slice 0: a beat may leave when the
  // slot ahead is empty or is itself leaving. This is what collapses bubbles.
  always_comb begin
    adv            = '0;
    adv[DEPTH-1]   = v[DEPTH-1] & out_ready_i;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      adv[k] = v[k] & (~v[k+1] | adv[k+1]);
    end
  end

  assign in_ready_o = rst_i & run & (~v[0] | adv[0]);
  assign in_fire    = in_valid_i & in_ready_o;

  // A slot that hands off without being refilled empties; flush empties all.
  always_comb begin
    load    = '0;
    load[0] = in_fire;
    for (int k = 1; k < DEPTH; k++) begin
      load[k] = run & adv[k-1];
    end
    for (int k = 0; k < DEPTH; k++) begin
      clear[k] = flush_i | (run & adv[k] & ~load[k]);
      v_nxt[k] = load[k] | (v[k] & ~clear[k]);
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_slice
    if (k == 0) begin : g_head
      pipe_slice #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_slice (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (load[k]),
        .clear_i (clear[k]),
        .ctrl_i  (in_ctrl_i),
        .data_i  (in_data_i),
        .valid_o (v[k]),
        .ctrl_o  (ctrl[k]),
        .data_o  (data[k])
      );
    end else begin : g_body
      pipe_slice #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_slice (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (load[k]),
        .clear_i (clear[k]),
        .ctrl_i  (ctrl[k-1]),
        .data_i  (data[k-1]),
        .valid_o (v[k]),
        .ctrl_o  (ctrl[k]),
        .data_o  (data[k])
      );
    end
  end

  // Occupancy tracks the popcount of the valid bits as they will be after
  // this edge, so it changes on the same edge as v.
  always_comb begin
    occ_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ_d = occ_d + OCC_W'(v_nxt[k]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign out_valid_o = v[DEPTH-1];
  assign out_ctrl_o  = ctrl[DEPTH-1];
  assign out_data_o  = data[DEPTH-1];
  assign occupancy_o = occ_q;

endmodule : pipe_stage_reg
`default_nettype wire
